axi_llc_evict_tracker: RTL

// Parametrised successor eviction/writeback engine of the LLC. Accepts in-order eviction descriptors from
// hit/miss detection, issues AW, streams way read data as W beats, tracks up to MaxOutstanding writebacks

---
 rtl/axi_llc_pkg.sv | 24 ++
 rtl/axi_llc_evict_queue.sv | 74 +++++++
 rtl/axi_llc_evict_tracker.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/axi_llc_pkg.sv
// Shared types for the LLC eviction/writeback path: AXI response codes and the queued descriptor.
package axi_llc_pkg;

   localparam int unsigned LlcAddrWidth = 64;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } axi_resp_e;

   typedef struct packed {
      logic [LlcAddrWidth-1:0] addr;
      logic [7:0]              len;
      logic                    evict;
      logic                    flush;
   } evict_entry_t;

   function automatic logic resp_is_err(input axi_resp_e resp);
      return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
   endfunction

endpackage

// File: rtl/axi_llc_evict_queue.sv
// In-order descriptor ring: write pointer fills, W pointer marks data sent, retire pointer drains.
module axi_llc_evict_queue
   import axi_llc_pkg::*;
#(
   parameter  int unsigned Depth = 4,
   localparam int unsigned CntW  = $clog2(Depth + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  evict_entry_t    push_entry,
   input  logic            w_advance,
   input  logic            retire,
   output evict_entry_t    w_entry,
   output evict_entry_t    head_entry,
   output logic            w_avail,
   output logic            head_ready,
   output logic [CntW-1:0] count
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

   evict_entry_t    mem [Depth];
   logic [Depth-1:0] w_done;
   logic [PtrW-1:0] wr_ptr;
   logic [PtrW-1:0] w_ptr;
   logic [PtrW-1:0] rt_ptr;
   // entries pushed whose W phase has not yet completed
   logic [CntW-1:0] w_pend;

   function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         w_ptr  <= '0;
         rt_ptr <= '0;
         count  <= '0;
         w_pend <= '0;
         w_done <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr]    <= push_entry;
            w_done[wr_ptr] <= 1'b0;
            wr_ptr         <= next_ptr(wr_ptr);
         end
         if (w_advance) begin
            w_done[w_ptr] <= 1'b1;
            w_ptr         <= next_ptr(w_ptr);
         end
         if (retire) begin
            rt_ptr <= next_ptr(rt_ptr);
         end
         if (push && !retire) begin
            count <= count + 1'b1;
         end else if (!push && retire) begin
            count <= count - 1'b1;
         end
         if (push && !w_advance) begin
            w_pend <= w_pend + 1'b1;
         end else if (!push && w_advance) begin
            w_pend <= w_pend - 1'b1;
         end
      end
   end

   assign w_entry    = mem[w_ptr];
   assign head_entry = mem[rt_ptr];
   assign w_avail    = (w_pend != '0);
   assign head_ready = (count != '0) && w_done[rt_ptr];

endmodule

// File: rtl/axi_llc_evict_tracker.sv
// LLC eviction engine: issues AW per dirty descriptor, streams way data as W, retires in order on B.
module axi_llc_evict_tracker
   import axi_llc_pkg::*;
#(
   parameter int unsigned AddrWidth      = 64,
   parameter int unsigned DataWidth      = 64,
   parameter int unsigned IdWidth        = 4,
   parameter int unsigned AxiId          = 0,
   parameter int unsigned MaxOutstanding = 4
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic [AddrWidth-1:0]                   desc_addr_i,
   input  logic [7:0]                             desc_len_i,
   input  logic                                   desc_evict_i,
   input  logic                                   desc_flush_i,
   input  logic                                   desc_valid_i,
   output logic                                   desc_ready_o,
   output logic [AddrWidth-1:0]                   desc_addr_o,
   output logic                                   desc_flush_o,
   output logic                                   desc_err_o,
   output logic                                   desc_valid_o,
   input  logic                                   desc_ready_i,
   output logic [AddrWidth-1:0]                   aw_addr_o,
   output logic [7:0]                             aw_len_o,
   output logic [IdWidth-1:0]                     aw_id_o,
   output logic                                   aw_valid_o,
   input  logic                                   aw_ready_i,
   input  logic [DataWidth-1:0]                   rd_data_i,
   input  logic                                   rd_valid_i,
   output logic                                   rd_ready_o,
   output logic [DataWidth-1:0]                   w_data_o,
   output logic                                   w_last_o,
   output logic                                   w_valid_o,
   input  logic                                   w_ready_i,
   input  logic [1:0]                             b_resp_i,
   input  logic                                   b_valid_i,
   output logic                                   b_ready_o,
   output logic [$clog2(MaxOutstanding+1)-1:0]    outstanding_o,
   output logic                                   flush_done_o,
   output logic                                   idle_o
);

   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

   evict_entry_t    push_entry;
   evict_entry_t    w_entry;
   evict_entry_t    head_entry;
   logic            push;
   logic            w_advance;
   logic            retire;
   logic            w_avail;
   logic            head_ready;
   logic [CntW-1:0] count;
   logic [7:0]      beat;
   logic            w_is_evict;
   logic            w_hs;
   logic            out_free;
   logic            unused_fields;

   axi_llc_evict_queue #(
      .Depth (MaxOutstanding)
   ) u_queue (
      .clk        (clk_i),
      .rst        (rst_i),
      .push       (push),
      .push_entry (push_entry),
      .w_advance  (w_advance),
      .retire     (retire),
      .w_entry    (w_entry),
      .head_entry (head_entry),
      .w_avail    (w_avail),
      .head_ready (head_ready),
      .count      (count)
   );

   // ready looks at registered occupancy only, so a same-cycle retire never frees a full queue
   assign desc_ready_o = !rst_i && !aw_valid_o && (count < CntW'(MaxOutstanding));
   assign push         = desc_valid_i && desc_ready_o;

   always_comb begin
      push_entry       = '0;
      push_entry.addr  = LlcAddrWidth'(desc_addr_i);
      push_entry.len   = desc_len_i;
      push_entry.evict = desc_evict_i;
      push_entry.flush = desc_flush_i;
   end

   assign w_is_evict = w_avail && w_entry.evict;
   assign w_valid_o  = w_is_evict && rd_valid_i;
   assign rd_ready_o = w_is_evict && w_ready_i;
   assign w_data_o   = rd_data_i;
   assign w_last_o   = w_is_evict && (beat == w_entry.len);
   assign w_hs       = w_valid_o && w_ready_i;
   assign w_advance  = (w_avail && !w_entry.evict) || (w_hs && w_last_o);

   assign out_free  = !desc_valid_o || desc_ready_i;
   assign b_ready_o = head_ready && head_entry.evict && out_free;
   assign retire    = head_ready && out_free && (!head_entry.evict || b_valid_i);

   assign aw_id_o       = IdWidth'(AxiId);
   assign outstanding_o = count;
   assign idle_o        = (count == '0) && !aw_valid_o && !desc_valid_o;
   assign unused_fields = ^{w_entry.addr, w_entry.flush, head_entry.len};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         beat         <= '0;
         aw_valid_o   <= 1'b0;
         aw_addr_o    <= '0;
         aw_len_o     <= '0;
         desc_valid_o <= 1'b0;
         desc_addr_o  <= '0;
         desc_flush_o <= 1'b0;
         desc_err_o   <= 1'b0;
         flush_done_o <= 1'b0;
      end else begin
         if (w_hs) begin
            beat <= w_last_o ? 8'd0 : beat + 8'd1;
         end

         if (push && desc_evict_i) begin
            aw_valid_o <= 1'b1;
            aw_addr_o  <= desc_addr_i;
            aw_len_o   <= desc_len_i;
         end else if (aw_ready_i) begin
            aw_valid_o <= 1'b0;
         end

         if (retire) begin
            desc_valid_o <= 1'b1;
            desc_addr_o  <= head_entry.addr[AddrWidth-1:0];
            desc_flush_o <= head_entry.flush;
            desc_err_o   <= head_entry.evict && resp_is_err(axi_resp_e'(b_resp_i));
         end else if (desc_ready_i) begin
            desc_valid_o <= 1'b0;
         end

         flush_done_o <= retire && head_entry.flush;
      end
   end

endmodule
